hmlf6_vq_ctrl: RTL and testbench

Vector-quantizer and sequencing controller for the 6-element, 2nd-order MIS shaping loop filter.
- Each clock it turns a 0..6 input code into the 6-bit element-select vector SV that drives the filter and the unit DAC cells. It enables the elements whose filter outputs SFM are largest.
- It owns filter start-up and clear: it drives the filter's active-low reset.
- It monitors the filter outputs for overload and recovers automatically.

---
 rtl/hmlf6_vq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hmlf6_vq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hmlf6_vq_ctrl.sv
// Vector quantizer and sequencing controller for the 6-element 2nd-order MIS loop filter.
// Picks the k largest filter outputs with rotated tie-breaking, owns filter clear, recovers from overload.
module hmlf6_vq_ctrl #(
    parameter int CLR_CYC = 2,
    parameter int OVL_TH  = 20,
    parameter int OVL_CNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bypass,
    input  logic [2:0]        din,
    input  logic signed [5:0] sfm5,
    input  logic signed [5:0] sfm4,
    input  logic signed [5:0] sfm3,
    input  logic signed [5:0] sfm2,
    input  logic signed [5:0] sfm1,
    input  logic signed [5:0] sfm0,
    output logic [5:0]        sv,
    output logic              filt_rstn,
    output logic              ovl_flag,
    input  logic              ovl_clr,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_r, state_nxt;
    logic [3:0]        clr_cnt_r;
    logic [7:0]        ovl_cnt_r;
    logic [2:0]        ptr_r;
    logic [5:0]        sv_r, sv_nxt;
    logic              filt_rstn_r;
    logic              ovl_flag_r;

    logic signed [5:0] sfm_a [6];
    logic [2:0]        rank_s [6];
    logic [5:0]        sel_s, th_s, ovl_s;
    logic [2:0]        k_s, ptr_nxt;
    logic [3:0]        psum_s;
    logic              any_ovl, trigger, run_stay;

    // Rotated position of element x relative to the tie-break pointer p.
    function automatic logic [2:0] rot(input logic [2:0] x, input logic [2:0] p);
        if (x >= p) rot = x - p;
        else        rot = x + 3'd6 - p;
    endfunction

    // Magnitude in 7 bits so that -32 maps to +32.
    function automatic logic [6:0] mag7(input logic signed [5:0] v);
        logic [6:0] ext;
        ext = {v[5], v};
        if (v[5]) mag7 = 7'd0 - ext;
        else      mag7 = ext;
    endfunction

    assign sfm_a[0] = sfm0;
    assign sfm_a[1] = sfm1;
    assign sfm_a[2] = sfm2;
    assign sfm_a[3] = sfm3;
    assign sfm_a[4] = sfm4;
    assign sfm_a[5] = sfm5;

    assign k_s     = (din > 3'd6) ? 3'd6 : din;
    assign psum_s  = {1'b0, ptr_r} + {1'b0, k_s};
    assign ptr_nxt = (psum_s >= 4'd6) ? 3'(psum_s - 4'd6) : psum_s[2:0];

    // Rank every element: number of others that beat it by value, then by rotated index.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            rank_s[i] = 3'd0;
            for (int j = 0; j < 6; j++) begin
                if (j != i && ((sfm_a[j] > sfm_a[i]) ||
                    (sfm_a[j] == sfm_a[i] && rot(3'(j), ptr_r) < rot(3'(i), ptr_r)))) begin
                    rank_s[i] = rank_s[i] + 3'd1;
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
            sel_s[i] = (rank_s[i] < k_s);
            th_s[i]  = (3'(i) < k_s);
            ovl_s[i] = (mag7(sfm_a[i]) >= 7'(OVL_TH));
        end
    end

    assign any_ovl = |ovl_s;
    assign trigger = (state_r == RUN) && en && !bypass && any_ovl &&
                     (ovl_cnt_r >= 8'(OVL_CNT - 1));

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state_r;
        sv_nxt    = 6'd0;
        case (state_r)
            IDLE: begin
                if (en) state_nxt = CLEAR;
                else    state_nxt = IDLE;
            end
            CLEAR: begin
                if (!en)                               state_nxt = IDLE;
                else if (clr_cnt_r == 4'(CLR_CYC - 1)) state_nxt = RUN;
                else                                   state_nxt = CLEAR;
            end
            RUN: begin
                if (!en)          state_nxt = IDLE;
                else if (trigger) state_nxt = CLEAR;
                else              state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_r == RUN && state_nxt == RUN) sv_nxt = bypass ? th_s : sel_s;
        else                                    sv_nxt = 6'd0;
    end

    assign run_stay = (state_r == RUN) && (state_nxt == RUN);

    // State, outputs, pointer and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            sv_r        <= 6'd0;
            filt_rstn_r <= 1'b0;
            clr_cnt_r   <= 4'd0;
            ovl_cnt_r   <= 8'd0;
            ptr_r       <= 3'd0;
        end else begin
            state_r     <= state_nxt;
            sv_r        <= sv_nxt;
            filt_rstn_r <= (state_nxt == RUN);
            if (state_r == CLEAR && state_nxt == CLEAR) clr_cnt_r <= clr_cnt_r + 4'd1;
            else                                        clr_cnt_r <= 4'd0;
            if (!run_stay)
                ovl_cnt_r <= 8'd0;
            else if (bypass)
                ovl_cnt_r <= ovl_cnt_r;
            else if (!any_ovl)
                ovl_cnt_r <= 8'd0;
            else if (ovl_cnt_r >= 8'(OVL_CNT))
                ovl_cnt_r <= 8'(OVL_CNT);
            else
                ovl_cnt_r <= ovl_cnt_r + 8'd1;
            if (state_nxt == RUN && state_r != RUN) ptr_r <= 3'd0;
            else if (run_stay && !bypass)           ptr_r <= ptr_nxt;
            else                                    ptr_r <= ptr_r;
        end
    end

    // Sticky overload flag; a new trigger wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovl_flag_r <= 1'b0;
        else if (trigger) ovl_flag_r <= 1'b1;
        else if (ovl_clr) ovl_flag_r <= 1'b0;
        else              ovl_flag_r <= ovl_flag_r;
    end

    assign sv        = sv_r;
    assign filt_rstn = filt_rstn_r;
    assign ovl_flag  = ovl_flag_r;
    assign state     = state_r;

endmodule

// File: tb/tb_hmlf6_vq_ctrl.sv
// Scoreboard bench for hmlf6_vq_ctrl: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry per clock, 1 ns after the rising edge.
module tb_hmlf6_vq_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] sv;
        logic       fr;
        logic       of;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              bypass = 1'b0;
    logic              ovl_clr = 1'b0;
    logic [2:0]        din = 3'd0;
    logic signed [5:0] sfm [6];
    logic [5:0]        sv;
    logic              filt_rstn;
    logic              ovl_flag;
    logic [1:0]        state;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    hmlf6_vq_ctrl #(.CLR_CYC(2), .OVL_TH(20), .OVL_CNT(8)) dut (
        .clk(clk), .rst(rst), .en(en), .bypass(bypass), .din(din),
        .sfm5(sfm[5]), .sfm4(sfm[4]), .sfm3(sfm[3]),
        .sfm2(sfm[2]), .sfm1(sfm[1]), .sfm0(sfm[0]),
        .sv(sv), .filt_rstn(filt_rstn), .ovl_flag(ovl_flag),
        .ovl_clr(ovl_clr), .state(state)
    );

    task automatic set_sfm(input logic signed [5:0] a5, input logic signed [5:0] a4,
                           input logic signed [5:0] a3, input logic signed [5:0] a2,
                           input logic signed [5:0] a1, input logic signed [5:0] a0);
        sfm[5] = a5; sfm[4] = a4; sfm[3] = a3;
        sfm[2] = a2; sfm[1] = a1; sfm[0] = a0;
    endtask

    // Apply inputs for one cycle; expected outputs after the following rising edge.
    task automatic step(input logic e, input logic byp, input logic oc, input logic [2:0] d,
                        input logic [1:0] st, input logic [5:0] s, input logic fr, input logic of);
        exp_t x;
        en = e; bypass = byp; ovl_clr = oc; din = d;
        @(posedge clk);
        x.st = st; x.sv = s; x.fr = fr; x.of = of;
        q.push_back(x);
        #2;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (state === e.st && sv === e.sv && filt_rstn === e.fr && ovl_flag === e.of) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_out t=%0t: got state=%0d sv=%b filt_rstn=%b ovl_flag=%b, want state=%0d sv=%b filt_rstn=%b ovl_flag=%b",
                         $time, state, sv, filt_rstn, ovl_flag, e.st, e.sv, e.fr, e.of);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
        #2;
        // reset state
        step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 6'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd0, 6'h00, 1'b0, 1'b0);
        rst = 1'b0;
        // start-up: two CLEAR cycles, RUN entry, first selection (ptr 0 -> 3 -> 0)
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd1, 6'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd1, 6'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd2, 6'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd2, 6'h07, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd2, 6'h38, 1'b1, 1'b0);
        // largest two: sfm4=7, sfm2=7
        set_sfm(-6'sd3, 6'sd7, 6'sd1, 6'sd7, -6'sd8, 6'sd0);
        step(1'b1, 1'b0, 1'b0, 3'd2, 2'd2, 6'h14, 1'b1, 1'b0);
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
        step(1'b1, 1'b0, 1'b0, 3'd2, 2'd2, 6'h0C, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd2, 2'd2, 6'h30, 1'b1, 1'b0);
        // rotation with k=4, then clamp 7 -> 6, then k=0
        step(1'b1, 1'b0, 1'b0, 3'd4, 2'd2, 6'h0F, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd4, 2'd2, 6'h33, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd4, 2'd2, 6'h3C, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd7, 2'd2, 6'h3F, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        // ties between sfm3 and sfm1 resolved by rotated index (ptr 0,1,2)
        set_sfm(6'sd0, 6'sd0, 6'sd5, 6'sd0, 6'sd5, 6'sd0);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 6'h02, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 6'h02, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 6'h08, 1'b1, 1'b0);
        // ptr=3: sfm0 largest, then the -5 tie goes to element 3
        set_sfm(-6'sd5, -6'sd5, -6'sd5, -6'sd5, -6'sd5, -6'sd1);
        step(1'b1, 1'b0, 1'b0, 3'd2, 2'd2, 6'h09, 1'b1, 1'b0);
        // seven overloaded cycles then 19 (below threshold): no clear
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, -6'sd20);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd19);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        // eight overloaded cycles (mixed -20, -32, +20) -> CLEAR and flag on the 8th edge
        for (int i = 0; i < 7; i++) begin
            if (i % 3 == 0)      set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, -6'sd20);
            else if (i % 3 == 1) set_sfm(-6'sd32, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
            else                 set_sfm(6'sd0, 6'sd0, 6'sd20, 6'sd0, 6'sd0, 6'sd0);
            step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 6'h00, 1'b0, 1'b1);
        // en dropped on first CLEAR cycle, then a full CLEAR again
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 6'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 6'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 6'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        // bypass: thermometer, no overload counting, ptr held
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd31);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 3'd5, 2'd2, 6'h1F, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd7, 2'd2, 6'h3F, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd1, 2'd2, 6'h01, 1'b1, 1'b0);
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
        step(1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 6'h01, 1'b1, 1'b0);
        // trigger coinciding with ovl_clr: set wins
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, -6'sd20);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 6'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 2'd1, 6'h00, 1'b0, 1'b1);
        set_sfm(6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd1, 6'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'd3, 2'd2, 6'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 3'd3, 2'd2, 6'h07, 1'b1, 1'b0);
        // en low from RUN -> IDLE
        step(1'b0, 1'b0, 1'b0, 3'd3, 2'd0, 6'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd3, 2'd0, 6'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
